// File: rtl/sd_bus_sched_pkg.sv
// sd_pkg: definitions shared by the SD bus scheduler and the SD command engines.
// Contents:
//   - scheduler state encoding (plain 3-bit constants)
//   - default timeout and inter-transaction gap lengths
//   - SD command indices used by the read/write engines
//   - grant codes driving the bus multiplexer
//   - grant_of(): the one place that maps a state to its bus owner
package sd_pkg;

   localparam int TIMEOUT_CYC_DEF = 4096;
   localparam int GAP_CYC_DEF     = 8;

   // READ_SINGLE_BLOCK / WRITE_BLOCK command indices issued by the engines
   localparam logic [5:0] CMD17 = 6'd17;
   localparam logic [5:0] CMD24 = 6'd24;

   localparam logic [2:0] ST_INIT     = 3'd0;
   localparam logic [2:0] ST_IDLE     = 3'd1;
   localparam logic [2:0] ST_START_RD = 3'd2;
   localparam logic [2:0] ST_RUN_RD   = 3'd3;
   localparam logic [2:0] ST_START_WR = 3'd4;
   localparam logic [2:0] ST_RUN_WR   = 3'd5;
   localparam logic [2:0] ST_GAP      = 3'd6;

   // GNT_NONE parks the card bus: CS high, MOSI high
   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_INIT = 2'd1,
      GNT_RD   = 2'd2,
      GNT_WR   = 2'd3
   } grant_t;

   // Only INIT and the RUN states hand the bus to an engine. The START
   // states keep it parked, so an engine never sees the bus before its
   // start pulse.
   function automatic grant_t grant_of(input logic [2:0] st);
      grant_t g;
      case (st)
         ST_INIT:   g = GNT_INIT;
         ST_RUN_RD: g = GNT_RD;
         ST_RUN_WR: g = GNT_WR;
         default:   g = GNT_NONE;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/sd_bus_sched_if.sv
// sd_bus_sched_if: every handshake and bus signal of the scheduler.
// Modport slave  : the scheduler.
// Modport master : the environment (init engine, clients, read/write engines, card pins).
//   init_o, init_MOSI, init_CSn         init engine status and bus drive
//   rd_req/wr_req, rd_addr/wr_addr      client requests (level, held until ack)
//   rd_ack/wr_ack, read_seq/write_seq   acceptance and engine-start pulses
//   cmd_addr                            block address of the granted transfer
//   rd_done/wr_done, rd_/wr_MOSI/CSn    engine completion pulses and bus drives
//   SD_MOSI, SD_CSn                     muxed card bus
//   busy, timeout_err                   status
interface sd_bus_sched_if;
   logic        init_o;
   logic        init_MOSI;
   logic        init_CSn;
   logic        rd_req;
   logic        wr_req;
   logic [31:0] rd_addr;
   logic [31:0] wr_addr;
   logic        rd_ack;
   logic        wr_ack;
   logic        read_seq;
   logic        write_seq;
   logic [31:0] cmd_addr;
   logic        rd_done;
   logic        wr_done;
   logic        rd_MOSI;
   logic        rd_CSn;
   logic        wr_MOSI;
   logic        wr_CSn;
   logic        SD_MOSI;
   logic        SD_CSn;
   logic        busy;
   logic        timeout_err;

   modport slave (
      input  init_o, init_MOSI, init_CSn, rd_req, wr_req, rd_addr, wr_addr,
             rd_done, wr_done, rd_MOSI, rd_CSn, wr_MOSI, wr_CSn,
      output rd_ack, wr_ack, read_seq, write_seq, cmd_addr,
             SD_MOSI, SD_CSn, busy, timeout_err
   );

   modport master (
      output init_o, init_MOSI, init_CSn, rd_req, wr_req, rd_addr, wr_addr,
             rd_done, wr_done, rd_MOSI, rd_CSn, wr_MOSI, wr_CSn,
      input  rd_ack, wr_ack, read_seq, write_seq, cmd_addr,
             SD_MOSI, SD_CSn, busy, timeout_err
   );
endinterface

// File: rtl/sd_bus_sched_mux.sv
// sd_bus_mux: 3:1 select of the card MOSI/CSn lines by grant code.
// Ports:
//   grant_i                     bus owner (GNT_NONE parks the bus high)
//   init_/rd_/wr_ mosi_i, csn_i engine bus drives
//   mosi_o, csn_o               card bus
module sd_bus_mux
   import sd_pkg::*;
(
   input  grant_t grant_i,
   input  logic   init_mosi_i,
   input  logic   init_csn_i,
   input  logic   rd_mosi_i,
   input  logic   rd_csn_i,
   input  logic   wr_mosi_i,
   input  logic   wr_csn_i,
   output logic   mosi_o,
   output logic   csn_o
);

   always_comb begin
      mosi_o = 1'b1;
      csn_o  = 1'b1;
      case (grant_i)
         GNT_INIT: begin mosi_o = init_mosi_i; csn_o = init_csn_i; end
         GNT_RD:   begin mosi_o = rd_mosi_i;   csn_o = rd_csn_i;   end
         GNT_WR:   begin mosi_o = wr_mosi_i;   csn_o = wr_csn_i;   end
         default:  ;
      endcase
   end

endmodule

// File: rtl/sd_bus_sched.sv
// sd_bus_sched: arbitrates the SD card bus between the init, read and write
// engines. It accepts one client transfer at a time, starts the matching
// engine, aborts it after TIMEOUT_CYC cycles, and keeps CS high for GAP_CYC
// cycles between transfers.
// Ports:
//   SD_CK  sole clock (rising edge)
//   rst    synchronous active-high reset
//   bus    sd_bus_sched_if.slave (requests, engine handshakes, card bus, status)
module sd_bus_sched
   import sd_pkg::*;
#(
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   parameter int GAP_CYC     = GAP_CYC_DEF
) (
   input  logic          SD_CK,
   input  logic          rst,
   sd_bus_sched_if.slave bus
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

   logic [2:0]    state_q, state_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic [GW-1:0] gap_cnt_q, gap_cnt_d;
   logic [31:0]   cmd_addr_q, cmd_addr_d;
   logic          last_wr_q, last_wr_d;
   logic          served_q, served_d;
   logic          in_run, run_done, to_zero, pick_wr, pulse_en;
   grant_t        grant;

   assign in_run   = (state_q == ST_RUN_RD) || (state_q == ST_RUN_WR);
   assign run_done = ((state_q == ST_RUN_RD) && bus.rd_done) ||
                     ((state_q == ST_RUN_WR) && bus.wr_done);
   assign to_zero  = (to_cnt_q == '0);

   // Tie-break: alternate with the last served type. Until the first
   // transfer has been served there is no history, so read wins.
   assign pick_wr  = bus.wr_req && (!bus.rd_req || (served_q && !last_wr_q));

   // Pulses are suppressed while reset or an init drop is pulling the FSM
   // back to INIT, so a transfer caught mid-flight leaves no trace.
   assign pulse_en = bus.init_o && !rst;

   always_comb begin
      state_d    = state_q;
      to_cnt_d   = to_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      cmd_addr_d = cmd_addr_q;
      last_wr_d  = last_wr_q;
      served_d   = served_q;
      if (!bus.init_o) begin
         state_d = ST_INIT;
      end else begin
         case (state_q)
            ST_INIT: state_d = ST_IDLE;
            ST_IDLE: begin
               // Address captured on the grant edge so it is already valid
               // while the engine sees its start pulse.
               if (pick_wr) begin
                  state_d    = ST_START_WR;
                  cmd_addr_d = bus.wr_addr;
               end else if (bus.rd_req) begin
                  state_d    = ST_START_RD;
                  cmd_addr_d = bus.rd_addr;
               end
            end
            ST_START_RD: begin
               state_d  = ST_RUN_RD;
               to_cnt_d = TW'(TIMEOUT_CYC);
            end
            ST_START_WR: begin
               state_d  = ST_RUN_WR;
               to_cnt_d = TW'(TIMEOUT_CYC);
            end
            ST_RUN_RD, ST_RUN_WR: begin
               // done and expiry both end the transfer; done only matters
               // for the output pulse, where it masks the timeout.
               if (run_done || to_zero) begin
                  state_d   = ST_GAP;
                  gap_cnt_d = GW'(GAP_CYC - 1);
                  last_wr_d = (state_q == ST_RUN_WR);
                  served_d  = 1'b1;
               end
               if (!to_zero) begin
                  to_cnt_d = to_cnt_q - TW'(1);
               end
            end
            ST_GAP: begin
               if (gap_cnt_q == '0) begin
                  state_d = ST_IDLE;
               end else begin
                  gap_cnt_d = gap_cnt_q - GW'(1);
               end
            end
            default: state_d = ST_INIT;
         endcase
      end
   end

   always_ff @(posedge SD_CK) begin
      if (rst) begin
         state_q    <= ST_INIT;
         to_cnt_q   <= '0;
         gap_cnt_q  <= '0;
         cmd_addr_q <= '0;
         last_wr_q  <= 1'b0;
         served_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         to_cnt_q   <= to_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         cmd_addr_q <= cmd_addr_d;
         last_wr_q  <= last_wr_d;
         served_q   <= served_d;
      end
   end

   assign bus.rd_ack      = pulse_en && (state_q == ST_START_RD);
   assign bus.read_seq    = pulse_en && (state_q == ST_START_RD);
   assign bus.wr_ack      = pulse_en && (state_q == ST_START_WR);
   assign bus.write_seq   = pulse_en && (state_q == ST_START_WR);
   assign bus.timeout_err = pulse_en && in_run && to_zero && !run_done;
   assign bus.cmd_addr    = cmd_addr_q;
   assign bus.busy        = rst || (state_q != ST_IDLE);

   // rst forces the init engine onto the bus even in the reset cycle itself,
   // before state_q has been cleared.
   assign grant = rst ? GNT_INIT : grant_of(state_q);

   sd_bus_mux u_mux (
      .grant_i     (grant),
      .init_mosi_i (bus.init_MOSI),
      .init_csn_i  (bus.init_CSn),
      .rd_mosi_i   (bus.rd_MOSI),
      .rd_csn_i    (bus.rd_CSn),
      .wr_mosi_i   (bus.wr_MOSI),
      .wr_csn_i    (bus.wr_CSn),
      .mosi_o      (bus.SD_MOSI),
      .csn_o       (bus.SD_CSn)
   );

endmodule
